// File: rtl/program_counter_stack.sv
// Program counter with a hardware call/return stack and sticky overflow/underflow flag.
// Optional PC-relative branching is compiled in when PC_REL_BRANCH_EN is defined.
module program_counter_stack #(
  parameter int ADDR_W = 8,
  parameter int STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               clear_n,
  input  logic               count,
  input  logic               load,
  input  logic [ADDR_W-1:0]  jump_address,
  input  logic               call,
  input  logic               ret,
  input  logic               rel,
  input  logic [ADDR_W-1:0]  offset,
  input  logic               err_clr,
  output logic [ADDR_W-1:0]  address,
  output logic [DEPTH_W-1:0] depth,
  output logic               stack_full,
  output logic               stack_empty,
  output logic               stack_err
);

  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [DEPTH_W-1:0] FULL_DEPTH = DEPTH_W'(STACK_DEPTH);

  logic [ADDR_W-1:0]  stack_mem [STACK_DEPTH];
  logic [ADDR_W-1:0]  next_address;
  logic [DEPTH_W-1:0] next_depth;
  logic               next_err;
  logic               push;
  logic               set_err;
  logic [IDX_W-1:0]   push_idx;
  logic [IDX_W-1:0]   pop_idx;

  assign stack_full  = (depth == FULL_DEPTH);
  assign stack_empty = (depth == '0);
  assign push_idx    = IDX_W'(depth);
  assign pop_idx     = IDX_W'(depth - DEPTH_W'(1));

`ifndef PC_REL_BRANCH_EN
  logic unused_rel;
  assign unused_rel = ^{rel, offset};
`endif

  // One action per cycle: call > ret > load > rel > count > hold.
  always_comb begin
    next_address = address;
    next_depth   = depth;
    push         = 1'b0;
    set_err      = 1'b0;
    if (call) begin
      if (!stack_full) begin
        push         = 1'b1;
        next_depth   = depth + DEPTH_W'(1);
        next_address = jump_address;
      end else begin
        set_err = 1'b1;
      end
    end else if (ret) begin
      if (!stack_empty) begin
        next_address = stack_mem[pop_idx];
        next_depth   = depth - DEPTH_W'(1);
      end else begin
        set_err = 1'b1;
      end
    end else if (load) begin
      next_address = jump_address;
`ifdef PC_REL_BRANCH_EN
    end else if (rel) begin
      next_address = address + offset;
`endif
    end else if (count) begin
      next_address = address + ADDR_W'(1);
    end
    // A new error in the same cycle as err_clr must survive the clear.
    next_err = (stack_err & ~err_clr) | set_err;
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      address   <= RESET_ADDR;
      depth     <= '0;
      stack_err <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) begin
        stack_mem[i] <= '0;
      end
    end else begin
      address   <= next_address;
      depth     <= next_depth;
      stack_err <= next_err;
      if (push) begin
        stack_mem[push_idx] <= address + ADDR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_program_counter_stack.sv
// Directed self-checking bench for program_counter_stack (ADDR_W=8, STACK_DEPTH=4).
// Relative-branch expectations follow PC_REL_BRANCH_EN as defined for the build.
module tb_program_counter_stack;

  logic       clk;
  logic       clear_n;
  logic       count;
  logic       load;
  logic [7:0] jump_address;
  logic       call;
  logic       ret;
  logic       rel;
  logic [7:0] offset;
  logic       err_clr;
  logic [7:0] address;
  logic [2:0] depth;
  logic       stack_full;
  logic       stack_empty;
  logic       stack_err;

  int numCompared;
  int numMismatched;

  program_counter_stack #(
    .ADDR_W(8),
    .STACK_DEPTH(4),
    .RESET_ADDR(8'h00)
  ) dut (
    .clk(clk),
    .clear_n(clear_n),
    .count(count),
    .load(load),
    .jump_address(jump_address),
    .call(call),
    .ret(ret),
    .rel(rel),
    .offset(offset),
    .err_clr(err_clr),
    .address(address),
    .depth(depth),
    .stack_full(stack_full),
    .stack_empty(stack_empty),
    .stack_err(stack_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    numCompared++;
    if (observed !== expected) begin
      numMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drives one cycle of strobes, then samples 1 time unit after the edge.
  task automatic applyStimulus(input logic c, input logic r, input logic l, input logic rl,
                               input logic cnt, input logic [7:0] ja, input logic [7:0] off,
                               input logic ec);
    call = c; ret = r; load = l; rel = rl; count = cnt;
    jump_address = ja; offset = off; err_clr = ec;
    @(posedge clk);
    #1;
    call = 0; ret = 0; load = 0; rel = 0; count = 0; err_clr = 0;
  endtask

  task automatic checkState(input string tag, input logic [7:0] a, input logic [2:0] d, input logic e);
    checkOutput({tag, ".addr"}, 32'(address), 32'(a));
    checkOutput({tag, ".depth"}, 32'(depth), 32'(d));
    checkOutput({tag, ".err"}, 32'(stack_err), 32'(e));
  endtask

  logic [7:0] expRel1;
  logic [7:0] expRel2;
  logic [7:0] expRel3;

  initial begin
    numCompared = 0;
    numMismatched = 0;
    clear_n = 0; call = 0; ret = 0; load = 0; rel = 0; count = 0;
    jump_address = 0; offset = 0; err_clr = 0;
`ifdef PC_REL_BRANCH_EN
    expRel1 = 8'h0C; expRel2 = 8'h6F; expRel3 = 8'h32;
`else
    expRel1 = 8'h10; expRel2 = 8'hF0; expRel3 = 8'h31;
`endif

    #3;
    checkState("reset", 8'h00, 3'd0, 1'b0);
    checkOutput("reset.empty", 32'(stack_empty), 32'd1);
    checkOutput("reset.full", 32'(stack_full), 32'd0);
    @(posedge clk);
    #1 clear_n = 1;

    for (int i = 1; i <= 256; i++) begin
      applyStimulus(0, 0, 0, 0, 1, 8'h00, 8'h00, 0);
      checkOutput("countwrap.addr", 32'(address), 32'(i % 256));
      checkOutput("countwrap.empty", 32'(stack_empty), 32'd1);
    end
    checkOutput("countwrap.depth", 32'(depth), 32'd0);

    applyStimulus(0, 0, 1, 0, 0, 8'h10, 8'h00, 0);
    checkState("nest.load", 8'h10, 3'd0, 1'b0);
    applyStimulus(1, 0, 0, 0, 0, 8'h40, 8'h00, 0);
    checkState("nest.call1", 8'h40, 3'd1, 1'b0);
    applyStimulus(1, 0, 0, 0, 0, 8'h80, 8'h00, 0);
    checkState("nest.call2", 8'h80, 3'd2, 1'b0);
    applyStimulus(0, 1, 0, 0, 0, 8'h00, 8'h00, 0);
    checkState("nest.ret1", 8'h41, 3'd1, 1'b0);
    applyStimulus(0, 1, 0, 0, 0, 8'h00, 8'h00, 0);
    checkState("nest.ret2", 8'h11, 3'd0, 1'b0);
    checkOutput("nest.empty", 32'(stack_empty), 32'd1);

    applyStimulus(1, 0, 0, 0, 0, 8'h20, 8'h00, 0);
    applyStimulus(1, 0, 0, 0, 0, 8'h30, 8'h00, 0);
    applyStimulus(1, 0, 0, 0, 0, 8'h40, 8'h00, 0);
    applyStimulus(1, 0, 0, 0, 0, 8'h50, 8'h00, 0);
    checkState("ovf.fill", 8'h50, 3'd4, 1'b0);
    checkOutput("ovf.full", 32'(stack_full), 32'd1);
    applyStimulus(1, 0, 0, 0, 0, 8'h60, 8'h00, 0);
    checkState("ovf.call5", 8'h50, 3'd4, 1'b1);
    checkOutput("ovf.full5", 32'(stack_full), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 8'h00, 8'h00, 1);
    checkState("ovf.errclr", 8'h50, 3'd4, 1'b0);
    applyStimulus(0, 1, 0, 0, 0, 8'h00, 8'h00, 0);
    checkState("unf.ret1", 8'h41, 3'd3, 1'b0);
    checkOutput("unf.notfull", 32'(stack_full), 32'd0);
    applyStimulus(0, 1, 0, 0, 0, 8'h00, 8'h00, 0);
    checkState("unf.ret2", 8'h31, 3'd2, 1'b0);
    applyStimulus(0, 1, 0, 0, 0, 8'h00, 8'h00, 0);
    checkState("unf.ret3", 8'h21, 3'd1, 1'b0);
    applyStimulus(0, 1, 0, 0, 0, 8'h00, 8'h00, 0);
    checkState("unf.ret4", 8'h12, 3'd0, 1'b0);
    applyStimulus(0, 1, 0, 0, 0, 8'h00, 8'h00, 0);
    checkState("unf.ret5", 8'h12, 3'd0, 1'b1);
    applyStimulus(0, 0, 0, 0, 0, 8'h00, 8'h00, 1);
    checkOutput("err.clr", 32'(stack_err), 32'd0);
    applyStimulus(0, 1, 0, 0, 0, 8'h00, 8'h00, 1);
    checkOutput("err.setwins", 32'(stack_err), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 8'h00, 8'h00, 1);
    checkOutput("err.clr2", 32'(stack_err), 32'd0);

    applyStimulus(0, 0, 1, 0, 0, 8'h20, 8'h00, 0);
    applyStimulus(1, 1, 0, 0, 1, 8'h30, 8'h00, 0);
    checkState("simul.callret", 8'h30, 3'd1, 1'b0);
    applyStimulus(0, 0, 1, 0, 1, 8'h05, 8'h00, 0);
    checkState("simul.loadcnt", 8'h05, 3'd1, 1'b0);
    applyStimulus(0, 1, 0, 0, 0, 8'h00, 8'h00, 0);
    checkState("simul.ret", 8'h21, 3'd0, 1'b0);
    applyStimulus(1, 0, 0, 0, 0, 8'h77, 8'h00, 0);
    applyStimulus(0, 1, 0, 0, 0, 8'h00, 8'h00, 0);
    checkState("b2b.callret", 8'h22, 3'd0, 1'b0);

    applyStimulus(0, 0, 1, 0, 0, 8'h10, 8'h00, 0);
    applyStimulus(0, 0, 0, 1, 0, 8'h00, 8'hFC, 0);
    checkOutput("rel.neg", 32'(address), 32'(expRel1));
    applyStimulus(0, 0, 1, 0, 0, 8'hF0, 8'h00, 0);
    applyStimulus(0, 0, 0, 1, 0, 8'h00, 8'h7F, 0);
    checkOutput("rel.wrap", 32'(address), 32'(expRel2));
    applyStimulus(0, 0, 1, 0, 0, 8'h30, 8'h00, 0);
    applyStimulus(0, 0, 0, 1, 1, 8'h00, 8'h02, 0);
    checkOutput("rel.count", 32'(address), 32'(expRel3));

    applyStimulus(1, 0, 0, 0, 0, 8'h11, 8'h00, 0);
    applyStimulus(1, 0, 0, 0, 0, 8'h22, 8'h00, 0);
    applyStimulus(1, 0, 0, 0, 0, 8'h55, 8'h00, 0);
    checkState("async.pre", 8'h55, 3'd3, 1'b0);
    #2 clear_n = 0;
    #1;
    checkState("async.reset", 8'h00, 3'd0, 1'b0);
    checkOutput("async.empty", 32'(stack_empty), 32'd1);
    @(posedge clk);
    #1;
    checkState("async.hold", 8'h00, 3'd0, 1'b0);
    clear_n = 1;
    applyStimulus(0, 1, 0, 0, 0, 8'h00, 8'h00, 0);
    checkState("async.underflow", 8'h00, 3'd0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
